// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for serial_adder_ctrl.
// The `sub` select exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             count;
    logic             busy;

    modport master (
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        output in_valid, in1, in2, out_ready,
        input  in_ready, out_valid, sum, count, busy
    );

    modport slave (
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        input  in_valid, in1, in2, out_ready,
        output in_ready, out_valid, sum, count, busy
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-add slice walked LSB-first over WIDTH bits.
// Define SERIAL_ADDER_SUB_EN to add the `sub` select (A - B via ~B + 1).
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_adder_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic             count_q;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub_q;
`endif

    logic             a_bit_d;
    logic             b_bit_d;
    logic [1:0]       slice_d;

    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    // {carry, sum} of x + y + cin from two half adders and an OR.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
        logic [1:0] h0;
        logic [1:0] h1;
        h0 = half_add(x, y);
        h1 = half_add(h0[0], cin);
        return {h0[1] | h1[1], h1[0]};
    endfunction

    always_comb begin
        a_bit_d = |(a_q & (WIDTH'(1) << idx_q));
`ifdef SERIAL_ADDER_SUB_EN
        b_bit_d = |(b_q & (WIDTH'(1) << idx_q)) ^ sub_q;
`else
        b_bit_d = |(b_q & (WIDTH'(1) << idx_q));
`endif
        slice_d = full_add(a_bit_d, b_bit_d, carry_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sum_q   <= '0;
            count_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.in1;
                        b_q     <= bus.in2;
                        sum_q   <= '0;
                        count_q <= 1'b0;
                        idx_q   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
                        sub_q   <= bus.sub;
                        carry_q <= bus.sub;
`else
                        carry_q <= 1'b0;
`endif
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q   <= sum_q | (WIDTH'(slice_d[0]) << idx_q);
                    carry_q <= slice_d[1];
                    idx_q   <= idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(WIDTH - 1)) begin
                        count_q <= slice_d[1];
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // in_ready is gated by rst_n so nothing is accepted while reset is held.
    assign bus.in_ready  = rst_n && (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == RUN);
    assign bus.sum       = sum_q;
    assign bus.count     = count_q;
endmodule
